step_driver: RTL and testbench

STEP_DRIVER -- requirements
Module: step_driver

---
 rtl/step_pkg.sv | 44 ++++
 rtl/step_timer.sv | 32 +++
 rtl/step_driver.sv | 85 ++++++++
 tb/tb_step_driver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared constants and helpers for the stepper driver: speed levels, coil
// pattern table, period arithmetic and phase sequencing.
package step_pkg;

  localparam int unsigned MAX_LEVEL  = 5;
  localparam int unsigned NUM_LEVELS = MAX_LEVEL + 1;

  // Indexed by phase 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
  localparam logic [7:0][3:0] COIL_TAB = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  typedef enum logic {
    FULL_STEP = 1'b0,
    HALF_STEP = 1'b1
  } step_mode_e;

  // Cycles per step at a given level: CLK_HZ*60 / (RPM*STEPS_PER_REV), halved in half-step mode
  function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                input int unsigned steps_per_rev,
                                                input int unsigned level,
                                                input logic        half);
    longint unsigned fp;
    fp = (64'(clk_hz) * 64'd60) / (64'(10 * (level + 1)) * 64'(steps_per_rev));
    return 32'(half ? fp / 64'd2 : fp);
  endfunction

  function automatic logic [2:0] clamp_level(input logic [2:0] value);
    return (value > 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : value;
  endfunction

  // Full-step mode lives on odd phases; an even phase left over from half-step
  // mode moves one position to reach the odd grid.
  function automatic logic [2:0] next_phase(input logic [2:0]  idx,
                                            input step_mode_e  mode,
                                            input logic        cw);
    logic [2:0] stride;
    if (mode == HALF_STEP || !idx[0]) stride = cw ? 3'd1 : 3'd7;
    else                              stride = cw ? 3'd2 : 3'd6;
    return idx + stride;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step period counter: counts while enabled, pulses tick on the last cycle of
// the period and reloads the period length whenever load is asserted.
module step_timer #(
  parameter int unsigned     CW         = 9,
  parameter logic [CW-1:0]   RESET_LAST = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic [CW-1:0] load_last,
  output logic          tick
);

  logic [CW-1:0] count;
  logic [CW-1:0] last;

  // Period is held as period-1 so the counter width suffices for the register.
  assign tick = enable && (count == last);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      last  <= RESET_LAST;
    end else begin
      if (!enable || tick) count <= '0;
      else                 count <= count + 1'b1;
      if (load) last <= load_last;
    end
  end

endmodule

// File: rtl/step_driver.sv
// Unipolar stepper coil sequencer: selectable speed level, direction and
// full/half-step mode, with settings latched only at step boundaries.
module step_driver
  import step_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned STEPS_PER_REV = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  input  logic       half_step,
  input  logic [2:0] speed_value,
  output logic [3:0] coil,
  output logic       step_tick,
  output logic [2:0] active_level
);

  localparam int unsigned FP0 = period_cycles(CLK_HZ, STEPS_PER_REV, 0, 1'b0);
  localparam int unsigned CW  = (FP0 > 1) ? $clog2(FP0) : 1;
  localparam int unsigned NUM_PERIODS = 2 * NUM_LEVELS;

  // Entries 0..5 full-step, 6..11 half-step; each holds period-1
  logic [CW-1:0] last_tab [NUM_PERIODS];

  for (genvar g = 0; g < NUM_PERIODS; g++) begin : g_last_tab
    assign last_tab[g] = CW'(period_cycles(CLK_HZ, STEPS_PER_REV, 32'(g % NUM_LEVELS),
                                           (g >= NUM_LEVELS) ? 1'b1 : 1'b0) - 1);
  end

  logic [2:0]  level_q;
  step_mode_e  mode_q;
  logic        dir_q;
  logic [2:0]  phase_q;
  logic [2:0]  phase_next;
  logic [2:0]  sel_level;
  step_mode_e  sel_mode;
  logic [3:0]  sel_index;
  logic        sample;

  always_comb begin
    sel_level  = clamp_level(speed_value);
    sel_mode   = step_mode_e'(half_step);
    sel_index  = {1'b0, sel_level} + ((sel_mode == HALF_STEP) ? 4'(NUM_LEVELS) : 4'd0);
    sample     = !enable || step_tick;
    phase_next = next_phase(phase_q, mode_q, dir_q);
  end

  step_timer #(
    .CW         (CW),
    .RESET_LAST (CW'(FP0 - 1))
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (sample),
    .load_last (last_tab[sel_index]),
    .tick      (step_tick)
  );

  // The step taken at a boundary uses the settings of the period that just ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      mode_q  <= FULL_STEP;
      dir_q   <= 1'b1;
      phase_q <= 3'd1;
      coil    <= COIL_TAB[3'd1];
    end else begin
      if (step_tick) begin
        phase_q <= phase_next;
        coil    <= COIL_TAB[phase_next];
      end
      if (sample) begin
        level_q <= sel_level;
        mode_q  <= sel_mode;
        dir_q   <= dir;
      end
    end
  end

  assign active_level = level_q;

endmodule

// File: tb/tb_step_driver.sv
// Self-checking bench for step_driver: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_step_driver;

  localparam int unsigned CLK_HZ = 12000;
  localparam int unsigned SPR    = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       dir = 1'b1;
  logic       half_step = 1'b0;
  logic [2:0] speed_value = 3'd0;
  logic [3:0] coil;
  logic       step_tick;
  logic [2:0] active_level;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  step_driver #(.CLK_HZ(CLK_HZ), .STEPS_PER_REV(SPR)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dir          (dir),
    .half_step    (half_step),
    .speed_value  (speed_value),
    .coil         (coil),
    .step_tick    (step_tick),
    .active_level (active_level)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cycle);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  function automatic int model_period(input int level, input bit half);
    int fp;
    fp = int'(CLK_HZ) * 60 / (10 * (level + 1) * int'(SPR));
    return half ? fp / 2 : fp;
  endfunction

  function automatic int model_next(input int idx, input bit half, input bit cw);
    int stride;
    stride = (half || (idx % 2 == 0)) ? 1 : 2;
    return cw ? (idx + stride) % 8 : (idx + 8 - stride) % 8;
  endfunction

  int   m_cnt, m_level, m_idx;
  bit   m_half, m_dir;
  bit   m_valid = 1'b0;
  logic m_tick;

  assign m_tick = m_valid && enable && (m_cnt == model_period(m_level, m_half) - 1);

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_cnt   <= 0;
      m_level <= 0;
      m_half  <= 1'b0;
      m_dir   <= 1'b1;
      m_idx   <= 1;
    end else begin
      if (m_tick) m_idx <= model_next(m_idx, m_half, m_dir);
      if (!enable || m_tick) begin
        m_cnt   <= 0;
        m_level <= (speed_value > 3'd5) ? 5 : int'(speed_value);
        m_half  <= half_step;
        m_dir   <= dir;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_tick", step_tick, m_tick);
      check("model_coil", coil, pat[m_idx]);
      check("model_level", active_level, m_level);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic tick_clk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick_clk();
      if (step_tick) begin
        at = cycle;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL tick_timeout: no step_tick within %0d cycles at cycle %0d", budget, cycle);
  endtask

  task automatic run_steps(input string name, input int start, input int n,
                           input int period, input logic [3:0] coils [4]);
    int prev;
    int t;
    prev = start - 1;
    for (int i = 0; i < n; i++) begin
      wait_tick(period + 10, t);
      if (t < 0) return;
      check({name, "_period"}, t - prev, period);
      prev = t;
      tick_clk();
      check({name, "_coil"}, coil, coils[i]);
    end
  endtask

  task automatic do_reset(input bit en, input bit hs, input bit d, input logic [2:0] sv);
    reset = 1'b1; enable = en; half_step = hs; dir = d; speed_value = sv;
    tick_clk(2);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, prev, nt, nc;
    logic [3:0] c;
    logic [3:0] exp_c [4];

    // Level 0 full-step clockwise straight out of reset
    reset = 1'b1; enable = 1'b1; dir = 1'b1; half_step = 1'b0; speed_value = 3'd0;
    tick_clk(3);
    check("reset_coil", coil, 4'b1100);
    check("reset_level", active_level, 0);
    check("reset_tick", step_tick, 0);
    reset = 1'b0;
    t0 = cycle;
    exp_c = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    run_steps("A", t0, 4, 360, exp_c);

    // Level 5 half-step counter-clockwise
    do_reset(1'b0, 1'b1, 1'b0, 3'd5);
    tick_clk(2);
    check("B_level", active_level, 5);
    enable = 1'b1;
    t0 = cycle;
    exp_c = '{4'b1000, 4'b1001, 4'b0001, 4'b0011};
    run_steps("B", t0, 4, 30, exp_c);

    // Speed change mid-period only takes effect at the boundary
    do_reset(1'b0, 1'b0, 1'b1, 3'd0);
    tick_clk();
    enable = 1'b1;
    t0 = cycle;
    tick_clk(100);
    speed_value = 3'd5;
    wait_tick(400, t);
    check("C_first_period", t - t0 + 1, 360);
    check("C_level_before", active_level, 0);
    tick_clk();
    check("C_level_after", active_level, 5);
    check("C_coil", coil, 4'b0110);
    prev = t;
    wait_tick(100, t);
    check("C_next_period", t - prev, 60);
    tick_clk();
    check("C_coil2", coil, 4'b0011);

    // Clamp of out-of-range speed values, loaded while disabled
    enable = 1'b0;
    speed_value = 3'd2;
    tick_clk();
    check("D_level2", active_level, 2);
    speed_value = 3'd7;
    tick_clk();
    check("D_clamp", active_level, 5);
    enable = 1'b1;
    t0 = cycle;
    exp_c = '{4'b1001, 4'b1100, 4'b0000, 4'b0000};
    run_steps("D", t0, 2, 60, exp_c);

    // Hold for 500 cycles mid-period, then a full period before the next step
    tick_clk(20);
    c = coil;
    enable = 1'b0;
    nt = 0; nc = 0;
    for (int i = 0; i < 500; i++) begin
      tick_clk();
      if (step_tick) nt++;
      if (coil != c) nc++;
    end
    check("E_hold_ticks", nt, 0);
    check("E_hold_coil_changes", nc, 0);
    enable = 1'b1;
    t0 = cycle;
    wait_tick(100, t);
    check("E_reenable_period", t - t0 + 1, 60);
    tick_clk();
    check("E_coil", coil, 4'b0110);
    // Dropping enable on the boundary cycle suppresses the step
    wait_tick(100, t);
    enable = 1'b0;
    tick_clk();
    check("E_suppress_coil", coil, 4'b0110);
    check("E_suppress_tick", step_tick, 0);

    // Half-step onto an even phase, then switch to full-step
    do_reset(1'b0, 1'b1, 1'b1, 3'd5);
    tick_clk();
    enable = 1'b1;
    t0 = cycle;
    wait_tick(40, t);
    check("F_first_period", t - t0 + 1, 30);
    tick_clk();
    check("F_coil_even", coil, 4'b0100);
    half_step = 1'b0;
    prev = t;
    wait_tick(40, t);
    check("F_half_period", t - prev, 30);
    tick_clk();
    check("F_coil_to_odd", coil, 4'b0110);
    prev = t;
    wait_tick(80, t);
    check("F_full_period", t - prev, 60);
    tick_clk();
    check("F_coil_full", coil, 4'b0011);
    tick_clk(10);
    reset = 1'b1;
    tick_clk();
    check("F_reset_coil", coil, 4'b1100);
    check("F_reset_level", active_level, 0);
    check("F_reset_tick", step_tick, 0);
    reset = 1'b0;

    // Randomized run checked cycle by cycle against the model
    for (int i = 0; i < 15000; i++) begin
      if (enable) begin
        if ($urandom_range(0, 399) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 99) < 2) speed_value = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) half_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) dir = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 1999) == 0);
      tick_clk();
    end
    reset = 1'b0;
    tick_clk(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
